button_gesture_decoder: RTL and testbench



---
 rtl/button_gesture_decoder_pkg.sv | 35 +++
 rtl/button_gesture_decoder_timer.sv | 64 ++++++
 rtl/button_gesture_decoder.sv | 136 +++++++++++++
 tb/tb_button_gesture_decoder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_gesture_decoder_pkg.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder_pkg
// Shared definitions for the button gesture decoder:
//   - FSM state encoding (3 bits)
//   - event bit positions, so downstream logic can pack the single-cycle
//     gesture pulses into one one-hot bus of width EVT_W
//   - max3() helper used to size the shared timer
// Optional feature macro: BUTTON_GESTURE_REPEAT_EN (auto-repeat ticks).
// -----------------------------------------------------------------------------
package button_gesture_decoder_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        WAIT_GAP  = 3'd2,
        PRESS2    = 3'd3,
        LONG_HELD = 3'd4
    } gesture_state_e;

    // Event bit positions within a one-hot event bus.
    localparam int unsigned EVT_SHORT  = 0;
    localparam int unsigned EVT_LONG   = 1;
    localparam int unsigned EVT_DOUBLE = 2;
    localparam int unsigned EVT_REPEAT = 3;
    localparam int unsigned EVT_W      = 4;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_gesture_decoder_timer.sv
// -----------------------------------------------------------------------------
// gesture_timer
// Saturating up-counter shared by all gesture phases, with equality flags
// for the last cycle of the long-press, double-press gap and repeat windows.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : synchronous clear (wins over enable)
//   en_i         : count enable
//   long_hit_o   : count == LONG_CYCLES-1
//   gap_hit_o    : count == DOUBLE_GAP_CYCLES-1 (never when the gap is 0)
//   rep_hit_o    : count == REPEAT_CYCLES-1; constant 0 unless
//                  BUTTON_GESTURE_REPEAT_EN is defined
// -----------------------------------------------------------------------------
module gesture_timer
    import button_gesture_decoder_pkg::*;
#(
    parameter int unsigned CNT_W             = 5,
    parameter int unsigned LONG_CYCLES       = 16,
    parameter int unsigned DOUBLE_GAP_CYCLES = 8
`ifdef BUTTON_GESTURE_REPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES     = 4
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic long_hit_o,
    output logic gap_hit_o,
    output logic rep_hit_o
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  =
        CNT_W'((DOUBLE_GAP_CYCLES == 0) ? 32'd0 : DOUBLE_GAP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values present before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            // Saturate at all-ones: a very long hold must never wrap back
            // into a compare window.
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign long_hit_o = (cnt_q == LONG_LAST);
    assign gap_hit_o  = (DOUBLE_GAP_CYCLES != 0) && (cnt_q == GAP_LAST);

`ifdef BUTTON_GESTURE_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    assign rep_hit_o = (cnt_q == REP_LAST);
`else
    assign rep_hit_o = 1'b0;
`endif

endmodule

// File: rtl/button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// button_gesture_decoder
// Classifies debounced button activity into short, long and double presses,
// each reported as a registered one-cycle pulse.
// Ports:
//   clk          : clock
//   rst_n        : asynchronous active-low reset; discards any sequence
//   in           : debounced button level, synchronous to clk
//   pressed      : registered, polarity-normalised level (1 = held)
//   short_press  : one-cycle pulse
//   long_press   : one-cycle pulse
//   double_press : one-cycle pulse
//   repeat_tick  : one-cycle auto-repeat pulse while a long press is held;
//                  only active when BUTTON_GESTURE_REPEAT_EN is defined
// -----------------------------------------------------------------------------
module button_gesture_decoder
    import button_gesture_decoder_pkg::*;
#(
    parameter bit          ACTIVE_LOW        = 1'b1,
    parameter int unsigned LONG_CYCLES       = 1000000,
    parameter int unsigned DOUBLE_GAP_CYCLES = 250000,
    parameter int unsigned REPEAT_CYCLES     = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in,
    output logic pressed,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic repeat_tick
);

    localparam int unsigned CNT_W =
        $clog2(max3(LONG_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES) + 1);

    logic             p;
    logic             pressed_q;
    gesture_state_e   state_q, state_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             timer_clear;
    logic             long_hit, gap_hit, rep_hit;

    assign p = in ^ ACTIVE_LOW;

    gesture_timer #(
        .CNT_W            (CNT_W),
        .LONG_CYCLES      (LONG_CYCLES),
        .DOUBLE_GAP_CYCLES(DOUBLE_GAP_CYCLES)
`ifdef BUTTON_GESTURE_REPEAT_EN
        ,
        .REPEAT_CYCLES    (REPEAT_CYCLES)
`endif
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timer_clear),
        .en_i      (state_q != IDLE),
        .long_hit_o(long_hit),
        .gap_hit_o (gap_hit),
        .rep_hit_o (rep_hit)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; that keeps this block free of inferred latches.
    always_comb begin
        state_d = state_q;
        evt_d   = '0;
        case (state_q)
            IDLE: begin
                if (p) state_d = PRESS1;
            end
            PRESS1: begin
                // Release is tested first so it wins over a same-cycle
                // long-press expiry.
                if (!p) begin
                    if (DOUBLE_GAP_CYCLES == 0) begin
                        state_d           = IDLE;
                        evt_d[EVT_SHORT]  = 1'b1;
                    end else begin
                        state_d = WAIT_GAP;
                    end
                end else if (long_hit) begin
                    state_d          = LONG_HELD;
                    evt_d[EVT_LONG]  = 1'b1;
                end
            end
            WAIT_GAP: begin
                // A press in the expiry cycle still counts as the second press.
                if (p) begin
                    state_d = PRESS2;
                end else if (gap_hit) begin
                    state_d          = IDLE;
                    evt_d[EVT_SHORT] = 1'b1;
                end
            end
            PRESS2: begin
                if (!p) begin
                    state_d           = IDLE;
                    evt_d[EVT_DOUBLE] = 1'b1;
                end
            end
            LONG_HELD: begin
                // rep_hit is tied low when auto-repeat is compiled out.
                if (!p) begin
                    state_d = IDLE;
                end else if (rep_hit) begin
                    evt_d[EVT_REPEAT] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A repeat tick restarts the period just like a state change does.
    assign timer_clear = (state_d != state_q) || evt_d[EVT_REPEAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
            evt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pressed_q <= p;
            evt_q     <= evt_d;
        end
    end

    assign pressed      = pressed_q;
    assign short_press  = evt_q[EVT_SHORT];
    assign long_press   = evt_q[EVT_LONG];
    assign double_press = evt_q[EVT_DOUBLE];
    assign repeat_tick  = evt_q[EVT_REPEAT];

endmodule

// File: tb/tb_button_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_gesture_decoder
// Scoreboard bench: each scenario is a list of alternating press/release run
// lengths; a run-length model predicts the cycle and kind of every gesture
// event and queues it, and a negedge monitor compares DUT pulses against the
// queue. The pressed output is compared every cycle against the driven level.
// -----------------------------------------------------------------------------
module tb_button_gesture_decoder;

    localparam int L  = 16;
    localparam int G  = 8;
    localparam int R  = 4;
    localparam bit AL = 1'b1;

    typedef enum int {K_NONE, K_SHORT, K_LONG, K_DOUBLE, K_REPEAT} kind_e;
    typedef struct {
        int    at;
        kind_e kind;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic in_lvl = 1'b1;
    logic pressed, short_press, long_press, double_press, repeat_tick;

    exp_t exp_q[$];
    int   runs[$];
    bit   p_at[int];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    button_gesture_decoder #(
        .ACTIVE_LOW       (AL),
        .LONG_CYCLES      (L),
        .DOUBLE_GAP_CYCLES(G),
        .REPEAT_CYCLES    (R)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in_lvl),
        .pressed     (pressed),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .repeat_tick (repeat_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int at, input kind_e k);
        exp_t e;
        e.at   = at;
        e.kind = k;
        exp_q.push_back(e);
    endtask

    // Run-length model. s0 is the clock edge that samples the first press.
    // Press of a samples: long if a > L (event at s0+L, repeats every R while
    // still held). Otherwise a release gap of g samples: short at release+G
    // when g > G, else the next press is a second press and double_press
    // follows its release.
    task automatic model(input int s0);
        int t, i, a, g, r;
        t = s0;
        i = 0;
        while (i + 1 < runs.size()) begin
            a = runs[i];
            if (a > L) begin
                expect_evt(t + L, K_LONG);
`ifdef BUTTON_GESTURE_REPEAT_EN
                for (int j = 1; L + j * R < a; j++) expect_evt(t + L + j * R, K_REPEAT);
`endif
                t += a + runs[i+1];
                i += 2;
            end else begin
                r = t + a;
                g = runs[i+1];
                if (G == 0) begin
                    expect_evt(r, K_SHORT);
                    t = r + g;
                    i += 2;
                end else if (g > G || i + 3 >= runs.size()) begin
                    expect_evt(r + G, K_SHORT);
                    t = r + g;
                    i += 2;
                end else begin
                    expect_evt(r + g + runs[i+2], K_DOUBLE);
                    t = r + g + runs[i+2] + runs[i+3];
                    i += 4;
                end
            end
        end
    endtask

    task automatic drive(input bit p, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_lvl = p ^ AL;
            p_at[cyc + 1] = p;
        end
    endtask

    task automatic add(input int a, input int b);
        runs.push_back(a);
        runs.push_back(b);
    endtask

    task automatic run_scenario();
        @(posedge clk);
        #1;
        model(cyc + 1);
        for (int i = 0; i < runs.size(); i++) drive((i % 2) == 0, runs[i]);
    endtask

    // Monitor: pops an expectation exactly at its cycle and compares kinds.
    always @(negedge clk) begin
        kind_e want, got;
        int    n_hi;
        if (rst_n) begin
            while (exp_q.size() != 0 && exp_q[0].at < cyc) begin
                check(exp_q[0].at >= cyc, "event_stale", cyc, exp_q[0].at);
                exp_q.delete(0);
            end
            want = K_NONE;
            if (exp_q.size() != 0 && exp_q[0].at == cyc) begin
                want = exp_q[0].kind;
                exp_q.delete(0);
            end
            n_hi = int'(short_press) + int'(long_press) + int'(double_press) + int'(repeat_tick);
            got  = short_press  ? K_SHORT  :
                   long_press   ? K_LONG   :
                   double_press ? K_DOUBLE :
                   repeat_tick  ? K_REPEAT : K_NONE;
            if (n_hi != 0) check(n_hi == 1, "one_event_per_cycle", n_hi, 1);
            if (want != K_NONE || got != K_NONE) check(got == want, "event_kind", int'(got), int'(want));
            if (p_at.exists(cyc)) check(pressed == p_at[cyc], "pressed", int'(pressed), int'(p_at[cyc]));
        end
    end

    initial begin
        // Reset state, with the button held so pressed must be forced low.
        in_lvl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check({pressed, short_press, long_press, double_press, repeat_tick} == 5'b0,
              "reset_state", int'({pressed, short_press, long_press, double_press, repeat_tick}), 0);
        @(negedge clk);
        in_lvl = 1'b1;
        #2 rst_n = 1'b1;
        drive(1'b0, 4);

        // Directed scenarios.
        runs.delete(); add(5, 20);            run_scenario();  // short
        runs.delete(); add(40, 20);           run_scenario();  // long
        runs.delete(); add(3, 4); add(3, 20); run_scenario();  // double
        runs.delete(); add(3, 8); add(3, 20); run_scenario();  // press in gap expiry cycle
        runs.delete(); add(3, 9); add(3, 20); run_scenario();  // gap expired -> two shorts
        runs.delete(); add(L, 12);            run_scenario();  // release at long expiry
        runs.delete(); add(L + 1, 12);        run_scenario();  // shortest long press
        runs.delete(); add(30, 12);           run_scenario();  // long with repeat window
        runs.delete(); add(2, 1); add(45, 12); run_scenario(); // long second press -> double

        // Reset during WAIT_GAP: no short_press may follow.
        drive(1'b1, 3);
        drive(1'b0, 3);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({pressed, short_press, long_press, double_press, repeat_tick} == 5'b0,
              "async_reset_gap", int'({pressed, short_press, long_press, double_press, repeat_tick}), 0);
        drive(1'b0, 2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b0, G + 6);

        // Reset while long_press is high: outputs clear without a clock edge.
        runs.delete(); add(L + 1, 1);
        @(posedge clk);
        #1;
        model(cyc + 1);
        drive(1'b1, L + 1);
        @(negedge clk);
        #2;
        check(pressed == 1'b1, "pressed_before_reset", int'(pressed), 1);
        rst_n = 1'b0;
        #1;
        check({pressed, short_press, long_press, double_press, repeat_tick} == 5'b0,
              "async_reset_long", int'({pressed, short_press, long_press, double_press, repeat_tick}), 0);
        drive(1'b0, 2);
        @(negedge clk);
        #2 rst_n = 1'b1;
        drive(1'b0, G + 6);

        // Randomised scenarios, biased toward the long-press boundary.
        repeat (60) begin
            int n, a;
            runs.delete();
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) a = L + $urandom_range(0, 1);
                else                           a = $urandom_range(1, L + 3 * R + 2);
                add(a, $urandom_range(1, G + 2));
            end
            runs[runs.size() - 1] = G + 1 + $urandom_range(1, 4);
            run_scenario();
        end

        drive(1'b0, G + 6);
        check(exp_q.size() == 0, "scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
